// File: rtl/aes_inv_round_ctrl_if.sv
// Bus bundle for the AES inverse round sequencer: ciphertext in, plaintext out,
// the round-key store lookup, and debug visibility of the round counter and FSM.
interface aes_inv_round_ctrl_if #(
    parameter int RKW = 4
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // the sender holds data stable while valid is high and ready is low.
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [RKW-1:0] rk_idx;
    logic [127:0]   rk_data;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;
    logic [RKW-1:0] round;
    logic [2:0]     fsm_state;

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy, round, fsm_state
    );

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy, round, fsm_state
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher: one decryption round per clock, one block in flight.
// Owns the 128-bit state register and round counter; round keys come from an external store.
module aes_inv_round_ctrl #(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARK   = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    localparam logic [RKW-1:0] NR_L  = RKW'(NR);
    localparam logic [RKW-1:0] NR_M1 = RKW'(NR - 1);
    localparam logic [RKW-1:0] ONE_L = RKW'(1);

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   st_q, st_d;
    logic [RKW-1:0] rnd_q, rnd_d;
    logic [RKW-1:0] rk_idx;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return ginv(t);
    endfunction

    // Byte n of the block sits at [127-8n -: 8]; byte n is row n%4, column n/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            rnd_q <= NR_L;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rnd_q <= rnd_d;
        end
    end

    // rk_idx is decoded from FSM and round only, so the key store sees it early in the cycle.
    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rnd_d  = rnd_q;
        rk_idx = NR_L;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d  = bus.in_data;
                    rnd_d = NR_L;
                    fsm_d = ARK;
                end
            end
            ARK: begin
                st_d  = st_q ^ bus.rk_data;
                rnd_d = NR_M1;
                fsm_d = ROUND;
            end
            ROUND: begin
                rk_idx = rnd_q;
                st_d   = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.rk_data);
                if (rnd_q <= ONE_L) begin
                    rnd_d = '0;
                    fsm_d = FINAL;
                end else begin
                    rnd_d = rnd_q - ONE_L;
                end
            end
            FINAL: begin
                rk_idx = '0;
                st_d   = inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.rk_data;
                fsm_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.busy      = (fsm_q != IDLE);
    assign bus.out_data  = st_q;
    assign bus.rk_idx    = rk_idx;
    assign bus.round     = rnd_q;
    assign bus.fsm_state = fsm_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: FIPS-197 vectors, per-round trace, backpressure,
// back-to-back blocks and reset corner cases, with a plaintext scoreboard on the output side.
module tb_aes_inv_round_ctrl;
    localparam int NR  = 10;
    localparam int RKW = 4;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ARK_A = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst_n;
    logic key_sel;
    int   pass_cnt;
    int   total_cnt;
    int   out_hs_cnt;
    int   cyc;

    logic [127:0] exp_q[$];
    logic [127:0] rka[16];
    logic [127:0] rkb[16];
    logic [7:0]   sb[256];

    aes_inv_round_ctrl_if #(.RKW(RKW)) bus ();

    aes_inv_round_ctrl #(.NR(NR), .RKW(RKW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Key store: combinational lookup by rk_idx, two key sets selectable between blocks.
    assign bus.rk_data = key_sel ? rkb[bus.rk_idx] : rka[bus.rk_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output scoreboard: a handshake completes at the next rising edge unless reset is asserted.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_output", 128'(bus.out_valid), 128'(0));
            end else begin
                chk("sb_plaintext", bus.out_data, exp_q.pop_front());
            end
            out_hs_cnt = out_hs_cnt + 1;
        end
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xv;
        logic [7:0] yv;
        for (int x = 0; x < 256; x++) begin
            xv  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yv = 8'(y);
                if (x != 0 && gm(xv, yv) == 8'h01) inv = yv;
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key, input bit which);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) begin
            if (which) rkb[k] = (k <= NR) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
            else       rka[k] = (k <= NR) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block, wait (bounded) for acceptance, push the expected plaintext on the accept edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit hold,
                        output int acc_cyc);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        while (bus.in_ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) chk("accept_timeout", 128'(bus.in_ready), 128'(1));
        step();
        exp_q.push_back(pt);
        acc_cyc = cyc;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int max_cyc);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) chk("out_valid_timeout", 128'(bus.out_valid), 128'(1));
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (out_hs_cnt < target && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) chk("handshake_timeout", 128'(out_hs_cnt), 128'(target));
    endtask

    initial begin
        int   acc_a;
        int   acc_b;
        int   h0;
        int   exp_rk;
        logic seen_ov;

        pass_cnt     = 0;
        total_cnt    = 0;
        out_hs_cnt   = 0;
        cyc          = 0;
        key_sel      = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        expand_key(KEY_A, 1'b0);
        expand_key(KEY_B, 1'b1);

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'(NR));
        chk("rst_round", 128'(bus.round), 128'(NR));
        rst_n = 1'b1;
        step();

        // FIPS-197 C.1 with a per-round trace of rk_idx, round and latency
        send(CT_A, PT_A, 1'b0, acc_a);
        bus.in_data = ~CT_A;
        chk("t1_ark_busy", 128'(bus.busy), 128'(1));
        chk("t1_ark_in_ready", 128'(bus.in_ready), 128'(0));
        chk("t1_ark_rk_idx", 128'(bus.rk_idx), 128'(NR));
        for (int i = 1; i <= NR; i++) begin
            step();
            exp_rk = (i == NR) ? 0 : NR - i;
            chk("t1_rk_idx", 128'(bus.rk_idx), 128'(exp_rk));
            chk("t1_round", 128'(bus.round), 128'(exp_rk));
            chk("t1_out_valid_low", 128'(bus.out_valid), 128'(0));
            if (i == 1) chk("t1_after_ark", bus.out_data, ARK_A);
        end
        step();
        chk("t1_latency_valid", 128'(bus.out_valid), 128'(1));
        chk("t1_latency_edges", 128'(cyc - acc_a), 128'(NR + 1));
        chk("t1_done_rk_idx", 128'(bus.rk_idx), 128'(NR));
        chk("t1_done_data", bus.out_data, PT_A);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t1_hs_count", 128'(out_hs_cnt), 128'(1));
        chk("t1_idle_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t1_idle_out_valid", 128'(bus.out_valid), 128'(0));

        // Output backpressure with ignored in_valid pulses
        send(CT_A, PT_A, 1'b0, acc_a);
        wait_out_valid(20);
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            chk("t3_hold_valid", 128'(bus.out_valid), 128'(1));
            chk("t3_hold_data", bus.out_data, PT_A);
            chk("t3_hold_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t3_hs_count", 128'(out_hs_cnt), 128'(2));
        chk("t3_idle_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t3_idle_out_valid", 128'(bus.out_valid), 128'(0));

        // Back-to-back with in_valid held; key set switched once the first block has left
        bus.out_ready = 1'b1;
        send(CT_A, PT_A, 1'b1, acc_a);
        bus.in_data = CT_B;
        wait_hs(3);
        key_sel = 1'b1;
        send(CT_B, PT_B, 1'b0, acc_b);
        chk("t4_accept_spacing", 128'(acc_b - acc_a), 128'(NR + 3));
        wait_hs(4);
        key_sel = 1'b0;
        chk("t4_hs_count", 128'(out_hs_cnt), 128'(4));

        // Reset in ROUND at round 5 discards the block
        send(CT_A, PT_A, 1'b0, acc_a);
        repeat (5) step();
        chk("t5_round_before_reset", 128'(bus.round), 128'(5));
        rst_n = 1'b0;
        exp_q.delete();
        step();
        chk("t5_rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t5_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t5_rst_busy", 128'(bus.busy), 128'(0));
        chk("t5_rst_state", bus.out_data, '0);
        chk("t5_rst_round", 128'(bus.round), 128'(NR));
        rst_n = 1'b1;
        seen_ov = 1'b0;
        repeat (15) begin
            step();
            seen_ov = seen_ov | bus.out_valid;
        end
        chk("t5_no_stale_output", 128'(seen_ov), 128'(0));
        send(CT_A, PT_A, 1'b0, acc_a);
        wait_hs(5);
        chk("t5_fresh_hs_count", 128'(out_hs_cnt), 128'(5));

        // Reset and out_ready on the same DONE edge: reset wins
        bus.out_ready = 1'b0;
        send(CT_A, PT_A, 1'b0, acc_a);
        wait_out_valid(20);
        h0 = out_hs_cnt;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        step();
        chk("t6_no_handshake", 128'(out_hs_cnt), 128'(h0));
        chk("t6_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t6_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t6_out_data", bus.out_data, '0);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("t6_stay_idle", 128'(bus.out_valid), 128'(0));

        chk("sb_queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
